// File: rtl/lr_shift_arbiter_pkg.sv
// Shared types for the left/right shift arbiter.
// Shift direction, requester ids and output-stage states.
package lr_shift_arbiter_pkg;

   typedef enum logic {
      Left  = 1'b0,
      Right = 1'b1
   } ShiftDir;

   localparam logic ID_A = 1'b0;
   localparam logic ID_B = 1'b1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_t;

endpackage

// File: rtl/lr_shift_arbiter_shift_core.sv
// Combinational left/right logical shifter.
// Vacated bit positions fill with zero.
module shift_core
   import lr_shift_arbiter_pkg::*;
#(
   parameter int width = 8
) (
   input  logic [width-1:0]         iBits,
   input  logic [$clog2(width)-1:0] shift,
   input  ShiftDir                  dir,
   output logic [width-1:0]         oBits
);

   // select shift direction
   always_comb begin
      oBits = iBits;
      if (dir == Left) begin
         oBits = iBits << shift;
      end else begin
         oBits = iBits >> shift;
      end
   end

endmodule

// File: rtl/lr_shift_arbiter.sv
// Round-robin arbiter between two shift requesters
// feeding one shared shifter and a one-entry result register.
module lr_shift_arbiter
   import lr_shift_arbiter_pkg::*;
#(
   parameter int width = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     a_valid,
   output logic                     a_ready,
   input  logic [width-1:0]         a_bits,
   input  logic [$clog2(width)-1:0] a_shift,
   input  ShiftDir                  a_dir,
   input  logic                     b_valid,
   output logic                     b_ready,
   input  logic [width-1:0]         b_bits,
   input  logic [$clog2(width)-1:0] b_shift,
   input  ShiftDir                  b_dir,
   output logic                     o_valid,
   input  logic                     o_ready,
   output logic [width-1:0]         o_bits,
   output logic                     o_id
);

   out_state_t                 r_state;
   out_state_t                 w_state_nxt;
   logic                       r_prio;
   logic [width-1:0]           r_bits;
   logic                       r_id;
   logic                       w_can_accept;
   logic                       w_gnt_b;
   logic                       w_accept;
   logic [width-1:0]           w_bits;
   logic [$clog2(width)-1:0]   w_shift;
   ShiftDir                    w_dir;
   logic [width-1:0]           w_result;

   // B wins when alone, or when both ask and B holds priority
   assign w_gnt_b = b_valid & (~a_valid | r_prio);

   // grant mux in front of the shared shifter
   assign w_bits  = w_gnt_b ? b_bits  : a_bits;
   assign w_shift = w_gnt_b ? b_shift : a_shift;
   assign w_dir   = w_gnt_b ? b_dir   : a_dir;

   shift_core #(
      .width (width)
   ) u_shift_core (
      .iBits (w_bits),
      .shift (w_shift),
      .dir   (w_dir),
      .oBits (w_result)
   );

   // output-stage state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // handshake decode and next state; no accept while in reset
   always_comb begin
      w_state_nxt  = r_state;
      w_can_accept = 1'b0;
      w_accept     = 1'b0;
      a_ready      = 1'b0;
      b_ready      = 1'b0;
      if (rst) begin
         w_can_accept = (r_state == EMPTY) | o_ready;
      end
      w_accept = w_can_accept & (a_valid | b_valid);
      a_ready  = w_can_accept & a_valid & ~w_gnt_b;
      b_ready  = w_can_accept & w_gnt_b;
      if (w_accept) begin
         w_state_nxt = FULL;
      end else if (r_state == FULL && o_ready) begin
         w_state_nxt = EMPTY;
      end
   end

   // result register and round-robin pointer
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_bits <= '0;
         r_id   <= ID_A;
         r_prio <= 1'b0;
      end else if (w_accept) begin
         r_bits <= w_result;
         r_id   <= w_gnt_b ? ID_B : ID_A;
         r_prio <= w_gnt_b ? 1'b0 : 1'b1;
      end
   end

   assign o_valid = (r_state == FULL);
   assign o_bits  = r_bits;
   assign o_id    = r_id;

endmodule

// File: tb/tb_lr_shift_arbiter.sv
// Scoreboard bench for lr_shift_arbiter (width 8).
// Reference model predicts grants and results; a monitor checks them.
module tb_lr_shift_arbiter;
   import lr_shift_arbiter_pkg::*;

   logic       clk;
   logic       rst;
   logic       a_valid, b_valid;
   logic       a_ready, b_ready;
   logic [7:0] a_bits, b_bits;
   logic [2:0] a_shift, b_shift;
   ShiftDir    a_dir, b_dir;
   logic       o_valid, o_ready;
   logic [7:0] o_bits;
   logic       o_id;

   lr_shift_arbiter #(.width(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .a_valid (a_valid),
      .a_ready (a_ready),
      .a_bits  (a_bits),
      .a_shift (a_shift),
      .a_dir   (a_dir),
      .b_valid (b_valid),
      .b_ready (b_ready),
      .b_bits  (b_bits),
      .b_shift (b_shift),
      .b_dir   (b_dir),
      .o_valid (o_valid),
      .o_ready (o_ready),
      .o_bits  (o_bits),
      .o_id    (o_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // expected results: {id, bits}
   logic [8:0] exp_q[$];

   // model state
   bit   m_full;
   logic m_last;
   int   b_wait;

   function automatic logic [7:0] ref_shift(input logic [7:0] v,
                                            input int sh,
                                            input ShiftDir d);
      int r;
      if (d == Left) r = int'(v) * (1 << sh);
      else           r = int'(v) / (1 << sh);
      return r[7:0];
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // one cycle: called at posedge+1, returns at next posedge+1
   task automatic step(input logic av, input logic bv,
                       input logic [7:0] ab, input logic [7:0] bb,
                       input logic [2:0] as, input logic [2:0] bs,
                       input ShiftDir ad, input ShiftDir bd,
                       input logic ordy, input logic rs);
      logic ea, eb, acc, win_b;
      a_valid = av; b_valid = bv;
      a_bits = ab; b_bits = bb;
      a_shift = as; b_shift = bs;
      a_dir = ad; b_dir = bd;
      o_ready = ordy; rst = rs;
      #1;
      win_b = bv && (!av || m_last == ID_A);
      acc = rs && (!m_full || ordy) && (av || bv);
      ea = acc && !win_b;
      eb = acc && win_b;
      check("ready", {a_ready, b_ready}, {ea, eb});
      if (acc) begin
         if (win_b)
            exp_q.push_back({ID_B, ref_shift(bb, int'(bs), bd)});
         else
            exp_q.push_back({ID_A, ref_shift(ab, int'(as), ad)});
      end
      if (eb) begin
         check("starve", (b_wait <= 1), 1);
         b_wait = 0;
      end else if (!bv || !rs) begin
         b_wait = 0;
      end else if (ea) begin
         b_wait++;
      end
      @(posedge clk);
      #1;
      if (!rs) begin
         m_full = 0;
         m_last = ID_B;
         exp_q.delete();
         check("rst_out", {o_valid, o_id, o_bits}, 0);
      end else begin
         if (acc) begin
            m_full = 1;
            m_last = win_b ? ID_B : ID_A;
         end else if (ordy) begin
            m_full = 0;
         end
         check("o_valid", o_valid, m_full);
      end
   endtask

   // monitor: compare each consumed result, and stability under stall
   logic       hold;
   logic [8:0] hold_val;
   initial hold = 1'b0;
   always @(negedge clk) begin
      logic [8:0] e;
      if (o_valid && hold)
         check("stable", {o_id, o_bits}, hold_val);
      if (o_valid && o_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected", {o_id, o_bits}, 9'h1FF);
         end else begin
            e = exp_q.pop_front();
            check("result", {o_id, o_bits}, e);
         end
      end
      hold     = o_valid && !o_ready && rst;
      hold_val = {o_id, o_bits};
   end

   initial begin
      rst = 1'b0; o_ready = 1'b0;
      a_valid = 1'b0; b_valid = 1'b0;
      a_bits = '0; b_bits = '0;
      a_shift = '0; b_shift = '0;
      a_dir = Left; b_dir = Left;
      m_full = 0; m_last = ID_B; b_wait = 0;
      repeat (2) @(posedge clk);
      #1;
      step(0, 0, 0, 0, 0, 0, Left, Left, 1, 0);
      // single A left, then single B right, shift 3 and 0
      step(1, 0, 8'h81, 0, 1, 0, Left, Left, 1, 1);
      step(0, 1, 0, 8'hF0, 0, 3, Left, Right, 1, 1);
      step(0, 1, 0, 8'hF0, 0, 0, Left, Right, 1, 1);
      step(1, 0, 8'h5A, 0, 0, 0, Left, Left, 1, 1);
      step(0, 0, 0, 0, 0, 0, Left, Left, 1, 1);
      // reset, then both valid continuously: A,B,A,B
      step(0, 0, 0, 0, 0, 0, Left, Left, 1, 0);
      for (int i = 0; i < 6; i++)
         step(1, 1, 8'h11 + 8'(i), 8'hC3 - 8'(i), 3'(i), 3'(i + 1),
              Left, Right, 1, 1);
      // backpressure for 3 cycles, then drain with new accept
      for (int i = 0; i < 3; i++)
         step(1, 1, 8'h77, 8'h99, 2, 2, Right, Left, 0, 1);
      step(1, 1, 8'h0F, 8'hF0, 4, 4, Left, Right, 1, 1);
      step(0, 0, 0, 0, 0, 0, Left, Left, 1, 1);
      // reset while full, then A first again
      step(1, 0, 8'hAA, 0, 1, 0, Left, Left, 0, 1);
      step(1, 1, 8'hAA, 8'hBB, 1, 1, Left, Left, 0, 0);
      step(1, 1, 8'h3C, 8'hC3, 1, 1, Right, Left, 1, 1);
      step(1, 1, 8'h3C, 8'hC3, 2, 2, Right, Left, 1, 1);
      // A streaming, B raised late
      step(1, 0, 8'h01, 0, 7, 0, Left, Left, 1, 1);
      step(1, 0, 8'h80, 0, 7, 0, Right, Left, 1, 1);
      for (int i = 0; i < 4; i++)
         step(1, 1, 8'hE7, 8'h7E, 3'(i), 3'(i), Left, Right, 1, 1);
      // random traffic
      for (int i = 0; i < 500; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'($urandom), 8'($urandom),
              3'($urandom), 3'($urandom),
              ShiftDir'($urandom_range(0, 1)),
              ShiftDir'($urandom_range(0, 1)),
              ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 63) != 0));
      // drain
      for (int i = 0; i < 3; i++)
         step(0, 0, 0, 0, 0, 0, Left, Left, 1, 1);
      check("drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lr_shift_arbiter.md
LR_SHIFT_ARBITER -- requirements
Module: lr_shift_arbiter

Interface
REQ-001 Parameter: width, default 8, data width of all bit vectors; SHALL be >= 2 and a power of two.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low.
REQ-004 a_valid  input  1  requester A holds a valid shift request.
REQ-005 a_ready  output  1  request A accepted this cycle.
REQ-006 a_bits / a_shift / a_dir  input  width / clog2(width) / ShiftDir  operand, shift amount, direction for A.
REQ-007 b_valid, b_ready, b_bits, b_shift, b_dir  SHALL mirror REQ-004..006 for requester B.
REQ-008 o_valid  output  1  result register holds a result.
REQ-009 o_ready  input  1  consumer accepts the result.
REQ-010 o_bits  output  width  shifted result.
REQ-011 o_id  output  1  source of the result: 0 = A, 1 = B.

Function
REQ-012 The block SHALL share one left/right shifter between A and B, one request per cycle at most.
REQ-013 Result SHALL be o_bits = bits << shift for Left, bits >> shift for Right; vacated positions zero-filled, result truncated to width.
REQ-014 Output stage SHALL be a one-entry register with FSM states EMPTY (o_valid=0) and FULL (o_valid=1).
REQ-015 can_accept = EMPTY or (FULL and o_ready); a_ready/b_ready SHALL be asserted only when can_accept is true and that requester is granted.
REQ-016 Latency: request accepted in cycle N SHALL appear on o_valid/o_bits/o_id in cycle N+1.
REQ-017 Transitions: EMPTY->FULL on accept; FULL->EMPTY on o_ready with no accept; FULL->FULL on o_ready with accept (back-to-back, full throughput); FULL holds without o_ready.
REQ-018 While FULL and o_ready=0, o_bits and o_id SHALL stay stable and no request SHALL be accepted.
REQ-019 Grant with only one valid requester SHALL go to that requester.
REQ-020 Grant with both valid SHALL be round-robin via 1-bit priority pointer prio: prio=0 favours A, prio=1 favours B.
REQ-021 prio SHALL update only on an accept, to the opposite of the accepted requester; it SHALL hold when no accept occurs.
REQ-022 ready SHALL be a combinational function of valids, prio and output state; it SHALL NOT depend on ready of the same interface.
REQ-023 A requester's valid dropping before accept SHALL be permitted; no request SHALL be latched without ready.
REQ-024 shift = 0 SHALL pass bits unchanged in either direction.

Reset
REQ-025 While rst=0 at a rising edge: state=EMPTY, o_valid=0, o_bits=0, o_id=0, prio=0; a_ready=b_ready=0 during that cycle.
REQ-026 Reset asserted with a result pending SHALL discard that result; no request SHALL be accepted in a reset cycle.
REQ-027 First accept SHALL be possible in the first cycle with rst=1.

Structure
REQ-028 Shared package SHALL hold the ShiftDir enum (Left, Right) and the requester-id encoding (A=0, B=1).
REQ-029 Shift datapath SHALL be one combinational sub-module, shift_core (iBits, shift, dir -> oBits), instantiated once after the grant mux.
REQ-030 Arbiter, FSM and output register SHALL live in lr_shift_arbiter; no other sub-modules.

Verification (width=8)
REQ-031 Single A, Left: a_bits=0x81, shift=1, o_ready=1 -> next cycle o_valid=1, o_bits=0x02, o_id=0.
REQ-032 Single B, Right: b_bits=0xF0, shift=3 -> o_bits=0x1E, o_id=1; shift=0 -> o_bits=0xF0.
REQ-033 Both valid continuously, o_ready=1, after reset -> grants A,B,A,B, one result per cycle, o_id 0,1,0,1.
REQ-034 Backpressure: o_ready=0 for 3 cycles while FULL -> a_ready=b_ready=0, o_bits stable; o_ready=1 -> drain and new accept in same cycle.
REQ-035 Reset mid-operation: rst=0 while FULL -> o_valid=0, prio=0 next cycle; after release both valid -> A granted first.
REQ-036 Starvation check: A valid always, B valid every cycle -> B accepted within 2 accepts of raising valid.
